// File: rtl/matrix_result_unloader.sv
// matrix_result_unloader
// Captures real/imaginary accumulator pairs from the complex dot-product
// datapath, buffers DIM*DIM entries in row-major order, then drains them
// over a valid/ready stream.
module matrix_result_unloader #(
    parameter int ANCHOPALABRA = 32,
    parameter int DIM          = 3
) (
    input  logic                            clk_fast,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            flagR,
    input  logic                            flagI,
    input  logic [ANCHOPALABRA-1:0]         accR,
    input  logic [ANCHOPALABRA-1:0]         accI,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [ANCHOPALABRA-1:0]         out_dataR,
    output logic [ANCHOPALABRA-1:0]         out_dataI,
    output logic [$clog2(DIM*DIM)-1:0]      out_addr,
    output logic [$clog2(DIM*DIM):0]        count,
    output logic                            done,
    output logic                            err
);

    localparam int N  = DIM * DIM;
    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(N - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]    r_state;
    logic          r_pendR;
    logic          r_pendI;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic          r_err;

    logic signed [ANCHOPALABRA-1:0] r_holdR;
    logic signed [ANCHOPALABRA-1:0] r_holdI;
    logic signed [ANCHOPALABRA-1:0] r_bufR [0:N-1];
    logic signed [ANCHOPALABRA-1:0] r_bufI [0:N-1];

    logic                           w_collect;
    logic                           w_commit;
    logic                           w_loadR;
    logic                           w_loadI;
    logic                           w_dropR;
    logic                           w_dropI;
    logic                           w_any_flag;
    logic [AW-1:0]                  w_wr_ptr;
    logic signed [ANCHOPALABRA-1:0] w_newR;
    logic signed [ANCHOPALABRA-1:0] w_newI;

    // Flags are only acted on while collecting; clear and reset discard them.
    assign w_collect  = rst & ~clear & (r_state == S_COLLECT);
    // A pair completes once both halves are either pending or arriving now.
    assign w_commit   = w_collect & (r_pendR | flagR) & (r_pendI | flagI);
    assign w_loadR    = w_collect & flagR & ~r_pendR & ~w_commit;
    assign w_loadI    = w_collect & flagI & ~r_pendI & ~w_commit;
    // A second flag for an already-pending half without its partner is lost.
    assign w_dropR    = w_collect & flagR & r_pendR & ~w_commit;
    assign w_dropI    = w_collect & flagI & r_pendI & ~w_commit;
    assign w_any_flag = flagR | flagI;
    // The write pointer always equals the number of committed entries.
    assign w_wr_ptr   = r_count[AW-1:0];
    assign w_newR     = flagR ? accR : r_holdR;
    assign w_newI     = flagI ? accI : r_holdI;

    // Output mux: entries are only visible while draining, zero otherwise.
    assign out_valid = (r_state == S_DRAIN);
    assign out_dataR = out_valid ? r_bufR[r_rd_ptr] : '0;
    assign out_dataI = out_valid ? r_bufI[r_rd_ptr] : '0;
    assign out_addr  = out_valid ? r_rd_ptr : '0;
    assign count     = r_count;
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

    // Control: collection/drain sequencing, pending halves and sticky error.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            r_state  <= S_COLLECT;
            r_pendR  <= 1'b0;
            r_pendI  <= 1'b0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_err    <= 1'b0;
        end else if (clear) begin
            r_state  <= S_COLLECT;
            r_pendR  <= 1'b0;
            r_pendI  <= 1'b0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_commit) begin
                        r_pendR <= 1'b0;
                        r_pendI <= 1'b0;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST_CNT) begin
                            r_state  <= S_DRAIN;
                            r_rd_ptr <= '0;
                        end
                    end else begin
                        if (w_loadR) r_pendR <= 1'b1;
                        if (w_loadI) r_pendI <= 1'b1;
                        if (w_dropR | w_dropI) r_err <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_any_flag) r_err <= 1'b1;
                    if (out_ready) begin
                        if (r_rd_ptr == LAST_ADDR) r_state <= S_DONE;
                        else r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                end
                S_DONE: begin
                    if (w_any_flag) r_err <= 1'b1;
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    // Data: hold registers for lone halves and the result buffer (never cleared).
    always_ff @(posedge clk_fast) begin
        if (w_loadR) r_holdR <= accR;
        if (w_loadI) r_holdI <= accI;
        if (w_commit) begin
            r_bufR[w_wr_ptr] <= w_newR;
            r_bufI[w_wr_ptr] <= w_newI;
        end
    end

endmodule

// File: tb/tb_matrix_result_unloader.sv
// Bench for matrix_result_unloader: queue-based behavioural model, a per-cycle
// compare process, directed scenarios and randomized flag/ready traffic.
module tb_matrix_result_unloader;

    localparam int W  = 32;
    localparam int DIM = 3;
    localparam int N  = DIM * DIM;
    localparam int AW = $clog2(N);

    logic          clk_fast = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          flagR = 1'b0;
    logic          flagI = 1'b0;
    logic [W-1:0]  accR = '0;
    logic [W-1:0]  accI = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_dataR;
    logic [W-1:0]  out_dataI;
    logic [AW-1:0] out_addr;
    logic [AW:0]   count;
    logic          done;
    logic          err;

    matrix_result_unloader #(.ANCHOPALABRA(W), .DIM(DIM)) dut (
        .clk_fast(clk_fast), .rst(rst), .clear(clear),
        .flagR(flagR), .flagI(flagI), .accR(accR), .accI(accI),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_dataR(out_dataR), .out_dataI(out_dataI), .out_addr(out_addr),
        .count(count), .done(done), .err(err)
    );

    always #5 clk_fast = ~clk_fast;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: committed pairs in a queue, a read index, done/err.
    logic [63:0]  col[$];
    int           mrd = 0;
    bit           mdone = 0;
    bit           merr = 0;
    bit           mpR = 0, mpI = 0;
    logic [W-1:0] mhR = '0, mhI = '0;

    always @(posedge clk_fast or negedge rst) begin
        if (!rst || clear) begin
            col.delete();
            mrd = 0; mdone = 0; merr = 0; mpR = 0; mpI = 0;
        end else if (col.size() < N) begin
            if ((mpR || flagR) && (mpI || flagI)) begin
                col.push_back({flagR ? accR : mhR, flagI ? accI : mhI});
                mpR = 0; mpI = 0; mrd = 0;
            end else begin
                if (flagR) begin
                    if (mpR) merr = 1;
                    else begin mhR = accR; mpR = 1; end
                end
                if (flagI) begin
                    if (mpI) merr = 1;
                    else begin mhI = accI; mpI = 1; end
                end
            end
        end else begin
            if (flagR || flagI) merr = 1;
            if (!mdone && out_ready) begin
                if (mrd == N - 1) mdone = 1;
                else mrd++;
            end
        end
    end

    // Compare DUT against the model one time unit after every active edge.
    always @(posedge clk_fast) begin
        #1;
        if (rst) begin
            automatic bit ev = (col.size() == N) && !mdone;
            automatic logic [63:0] ent = ev ? col[mrd] : 64'd0;
            chk("m_valid", out_valid, ev);
            chk("m_addr", out_addr, ev ? mrd : 0);
            chk("m_dataR", out_dataR, ent[63:32]);
            chk("m_dataI", out_dataI, ent[31:0]);
            chk("m_count", count, col.size());
            chk("m_done", done, mdone);
            chk("m_err", err, merr);
        end
    end

    task automatic cyc(input logic fr, input logic fi, input logic [W-1:0] ar,
                       input logic [W-1:0] ai, input logic rdy, input logic clr);
        @(negedge clk_fast);
        flagR = fr; flagI = fi; accR = ar; accI = ai; out_ready = rdy; clear = clr;
        @(posedge clk_fast);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) cyc(1'b0, 1'b0, $urandom, $urandom, rdy, 1'b0);
    endtask

    task automatic do_clear();
        cyc(1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
        chk("clr_count", count, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_err", err, 0);
        chk("clr_done", done, 0);
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    endtask

    task automatic drain(input bit rnd);
        int guard = 0;
        while (!done && guard < 200) begin
            cyc(1'b0, 1'b0, $urandom, $urandom, rnd ? 1'($urandom % 2) : 1'b1, 1'b0);
            guard++;
        end
        chk("drain_done", done, 1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk_fast);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_dataR", out_dataR, 0);
        chk("rst_addr", out_addr, 0);
        @(negedge clk_fast);
        rst = 1'b1;

        // Simultaneous flags, k<<11 and its negation
        for (int k = 1; k <= N; k++)
            cyc(1'b1, 1'b1, W'(k << 11), W'(-(k << 11)), 1'b1, 1'b0);
        chk("sim_count", count, 9);
        chk("sim_valid", out_valid, 1);
        chk("sim_addr0", out_addr, 0);
        chk("sim_dataR0", out_dataR, 32'h0000_0800);
        chk("sim_dataI0", out_dataI, 32'hFFFF_F800);
        for (int i = 0; i < N; i++) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
            if (i == 7) begin
                chk("sim_addr8", out_addr, 8);
                chk("sim_dataR8", out_dataR, 32'h0000_4800);
                chk("sim_dataI8", out_dataI, 32'hFFFF_B800);
            end
        end
        chk("sim_done", done, 1);
        chk("sim_novalid", out_valid, 0);
        chk("sim_err", err, 0);

        // Split flags: flagI three cycles after flagR
        do_clear();
        for (int e = 0; e < N; e++) begin
            cyc(1'b1, 1'b0, 32'h1000 + W'(e), $urandom, 1'b0, 1'b0);
            chk("split_cnt_r", count, e);
            idle(2, 1'b0);
            chk("split_cnt_idle", count, e);
            cyc(1'b0, 1'b1, $urandom, 32'h2000 + W'(e), 1'b0, 1'b0);
            chk("split_cnt_i", count, e + 1);
        end
        chk("split_dataR0", out_dataR, 32'h1000);
        chk("split_dataI0", out_dataI, 32'h2000);
        drain(1'b0);

        // Double flagR before flagI
        do_clear();
        cyc(1'b1, 1'b0, 32'h100, $urandom, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h200, $urandom, 1'b0, 1'b0);
        chk("dbl_err", err, 1);
        chk("dbl_count", count, 0);
        cyc(1'b0, 1'b1, $urandom, 32'h300, 1'b0, 1'b0);
        chk("dbl_count1", count, 1);
        fill(N - 1);
        chk("dbl_dataR0", out_dataR, 32'h100);
        chk("dbl_dataI0", out_dataI, 32'h300);
        drain(1'b1);
        chk("dbl_err_sticky", err, 1);

        // Backpressure pattern 1,0,0 repeating
        do_clear();
        fill(N);
        begin
            automatic int hs[$];
            automatic int guard = 0;
            while (!done && guard < 100) begin
                automatic logic rdy = (guard % 3 == 0);
                if (out_valid && rdy) hs.push_back(int'(out_addr));
                cyc(1'b0, 1'b0, $urandom, $urandom, rdy, 1'b0);
                guard++;
            end
            chk("bp_done", done, 1);
            chk("bp_hs_count", hs.size(), N);
            for (int i = 0; i < hs.size(); i++) chk("bp_hs_addr", hs[i], i);
        end

        // Clear in DRAIN after 4 handshakes, then a fresh collection
        do_clear();
        fill(N);
        idle(4, 1'b1);
        chk("clr_mid_addr", out_addr, 4);
        cyc(1'b0, 1'b0, $urandom, $urandom, 1'b1, 1'b1);
        chk("clr_mid_valid", out_valid, 0);
        chk("clr_mid_count", count, 0);
        fill(N);
        drain(1'b1);

        // Asynchronous reset after 5 commits
        do_clear();
        cyc(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
        fill(4);
        idle(1, 1'b0);
        chk("ar_count5", count, 5);
        chk("ar_err_pre", err, 1);
        @(negedge clk_fast);
        #2 rst = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_err", err, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_done", done, 0);
        chk("ar_dataR", out_dataR, 0);
        @(negedge clk_fast);
        rst = 1'b1;
        fill(N);
        chk("ar_refill", count, 9);
        drain(1'b0);

        // Flags in DRAIN and DONE
        do_clear();
        fill(N);
        cyc(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
        chk("od_err", err, 1);
        chk("od_count", count, 9);
        chk("od_addr", out_addr, 0);
        drain(1'b1);
        cyc(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("odn_done", done, 1);
        chk("odn_count", count, 9);
        chk("odn_valid", out_valid, 0);

        // Randomized flag and ready traffic
        for (int r = 0; r < 4; r++) begin
            automatic int guard = 0;
            do_clear();
            while (!done && guard < 400) begin
                cyc(1'($urandom % 3 == 0), 1'($urandom % 3 == 0), $urandom, $urandom,
                    1'($urandom % 2), 1'b0);
                guard++;
            end
            chk("rnd_done", done, 1);
        end

        idle(2, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
